// File: rtl/ysyx_23060072_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter slice.
//   XLEN      : data width
//   REG_AW    : register address width
//   NUM_REGS  : architectural register count
//   CNT_W     : default outstanding-write counter width
//   req_e     : requester encoding used by the round-robin pointer
package ysyx_23060072_wb_arbiter_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;
endpackage

// File: rtl/ysyx_23060072_wb_scoreboard.sv
// Per-register outstanding-write scoreboard.
//   clk, rst_n              : clock, async active-low reset
//   issue_valid_i/rd_i      : decoder dispatch of an rd-writing instruction
//   issue_ready_o           : low when the counter for issue_rd_i is saturated
//   commit_flag_i/addr_i    : registered regfile write (retires one count)
//   rs1_i, rs2_i            : decoder sources
//   hazard_o                : a source still has an uncommitted write
module ysyx_23060072_wb_scoreboard
  import ysyx_23060072_wb_arbiter_pkg::*;
#(
  parameter int REG_AW_P = REG_AW,
  parameter int CNT_W_P  = CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_i,
  input  logic [REG_AW_P-1:0] issue_rd_i,
  output logic                issue_ready_o,
  input  logic                commit_flag_i,
  input  logic [REG_AW_P-1:0] commit_addr_i,
  input  logic [REG_AW_P-1:0] rs1_i,
  input  logic [REG_AW_P-1:0] rs2_i,
  output logic                hazard_o
);
  localparam int NR = 1 << REG_AW_P;

  logic [CNT_W_P-1:0] cnt [NR];
  logic               issue_fire;
  logic [CNT_W_P-1:0] eff1, eff2;
  logic               bypass1, bypass2;

  assign issue_ready_o = !((issue_rd_i != '0) && (cnt[issue_rd_i] == '1));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  assign cnt[0] = '0;

  for (genvar r = 1; r < NR; r++) begin : g_cnt
    logic               inc, dec;
    logic [CNT_W_P-1:0] cnt_q;

    assign inc    = issue_fire && (issue_rd_i == REG_AW_P'(r));
    assign dec    = commit_flag_i && (commit_addr_i == REG_AW_P'(r));
    assign cnt[r] = cnt_q;

    // Simultaneous issue and commit cancel; a commit at zero is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            cnt_q <= '0;
      else if (inc && !dec)                  cnt_q <= cnt_q + CNT_W_P'(1);
      else if (dec && !inc && cnt_q != '0)   cnt_q <= cnt_q - CNT_W_P'(1);
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (rst_n && dec && !inc)
        assert (cnt_q != '0) else $error("scoreboard underflow on x%0d", r);
    end
`endif
  end

  // The write committing this cycle is visible through the regfile bypass,
  // so it no longer blocks a reader.
  assign bypass1 = commit_flag_i && (commit_addr_i == rs1_i);
  assign bypass2 = commit_flag_i && (commit_addr_i == rs2_i);
  assign eff1    = cnt[rs1_i] - (bypass1 ? CNT_W_P'(1) : CNT_W_P'(0));
  assign eff2    = cnt[rs2_i] - (bypass2 ? CNT_W_P'(1) : CNT_W_P'(0));

  assign hazard_o = ((rs1_i != '0) && (eff1 != '0)) ||
                    ((rs2_i != '0) && (eff2 != '0));
endmodule

// File: rtl/ysyx_23060072_wb_arbiter.sv
// Writeback arbiter: shares the regfile write port between EXU and LSU,
// registers the winning write, and hosts the RAW scoreboard.
//   clk, rst_n                  : clock, async active-low reset
//   issue_*, rs1_i, rs2_i       : decoder dispatch / hazard interface
//   exu_*, lsu_*                : writeback requesters (valid/ready)
//   wb_flag_o/reg_addr_o/wdata_o: registered regfile write port
// Build option: YSYX_23060072_WB_RR_EN selects two-way round-robin;
// otherwise LSU has fixed priority over EXU.
module ysyx_23060072_wb_arbiter
  import ysyx_23060072_wb_arbiter_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW,
  parameter int CNT_W_P  = CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid_i,
  input  logic [REG_AW_P-1:0] issue_rd_i,
  output logic                issue_ready_o,
  input  logic [REG_AW_P-1:0] rs1_i,
  input  logic [REG_AW_P-1:0] rs2_i,
  output logic                hazard_o,
  input  logic                exu_valid_i,
  input  logic [REG_AW_P-1:0] exu_rd_i,
  input  logic [XLEN_P-1:0]   exu_data_i,
  output logic                exu_ready_o,
  input  logic                lsu_valid_i,
  input  logic [REG_AW_P-1:0] lsu_rd_i,
  input  logic [XLEN_P-1:0]   lsu_data_i,
  output logic                lsu_ready_o,
  output logic                wb_flag_o,
  output logic [REG_AW_P-1:0] wb_reg_addr_o,
  output logic [XLEN_P-1:0]   wb_wdata_o
);
  logic                gnt_lsu, gnt_exu, hs;
  logic [REG_AW_P-1:0] sel_rd;
  logic [XLEN_P-1:0]   sel_data;

`ifdef YSYX_23060072_WB_RR_EN
  // ptr names the requester that wins the next collision.
  req_e ptr;
  assign gnt_lsu = lsu_valid_i && (!exu_valid_i || ptr == REQ_LSU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= REQ_EXU;
    else if (hs) ptr <= gnt_lsu ? REQ_EXU : REQ_LSU;
  end
`else
  assign gnt_lsu = lsu_valid_i;
`endif

  assign gnt_exu     = exu_valid_i && !gnt_lsu;
  assign hs          = gnt_lsu || gnt_exu;
  assign lsu_ready_o = gnt_lsu;
  assign exu_ready_o = gnt_exu;
  assign sel_rd      = gnt_lsu ? lsu_rd_i   : exu_rd_i;
  assign sel_data    = gnt_lsu ? lsu_data_i : exu_data_i;

  // x0 writes are accepted but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_flag_o     <= 1'b0;
      wb_reg_addr_o <= '0;
      wb_wdata_o    <= '0;
    end else begin
      wb_flag_o <= hs && (sel_rd != '0);
      if (hs) begin
        wb_reg_addr_o <= sel_rd;
        wb_wdata_o    <= sel_data;
      end
    end
  end

  ysyx_23060072_wb_scoreboard #(
    .REG_AW_P (REG_AW_P),
    .CNT_W_P  (CNT_W_P)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .commit_flag_i (wb_flag_o),
    .commit_addr_i (wb_reg_addr_o),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .hazard_o      (hazard_o)
  );
endmodule

// File: tb/tb_ysyx_23060072_wb_arbiter.sv
module tb_ysyx_23060072_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  rs1_i, rs2_i;
  logic        hazard_o;
  logic        exu_valid_i, lsu_valid_i;
  logic [4:0]  exu_rd_i, lsu_rd_i;
  logic [31:0] exu_data_i, lsu_data_i;
  logic        exu_ready_o, lsu_ready_o;
  logic        wb_flag_o;
  logic [4:0]  wb_reg_addr_o;
  logic [31:0] wb_wdata_o;

  int n_chk = 0;
  int n_fail = 0;

`ifdef YSYX_23060072_WB_RR_EN
  localparam bit FIRST_LSU = 1'b0;
`else
  localparam bit FIRST_LSU = 1'b1;
`endif

  always #5 clk = ~clk;

  ysyx_23060072_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
    .exu_valid_i(exu_valid_i), .exu_rd_i(exu_rd_i), .exu_data_i(exu_data_i), .exu_ready_o(exu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .wb_flag_o(wb_flag_o), .wb_reg_addr_o(wb_reg_addr_o), .wb_wdata_o(wb_wdata_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid_i = 1'b1;
    issue_rd_i    = rd;
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid_i = 0; issue_rd_i = 5'd5; rs1_i = 5'd5; rs2_i = 0;
    exu_valid_i = 0; exu_rd_i = 0; exu_data_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    #3;
    n_chk++; if ({wb_flag_o, wb_reg_addr_o, wb_wdata_o} !== 38'd0) begin n_fail++;
      $display("FAIL reset_wb: got %0b/%0d/%h want 0/0/0", wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    n_chk++; if (issue_ready_o !== 1'b1 || hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_sb: ready=%0b hazard=%0b want 1/0", issue_ready_o, hazard_o); end
    step(); step();
    rst_n = 1'b1;
    step();
    // Mid-stream reset with a write registered and a new request pending.
    issue(5'd6); issue(5'd6);
    exu_valid_i = 1; exu_rd_i = 5'd6; exu_data_i = 32'hA5A5A5A5; rs1_i = 5'd6;
    step();
    n_chk++; if (wb_flag_o !== 1'b1 || wb_reg_addr_o !== 5'd6) begin n_fail++;
      $display("FAIL reset_pre: flag=%0b addr=%0d want 1/6", wb_flag_o, wb_reg_addr_o); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({wb_flag_o, wb_reg_addr_o, wb_wdata_o} !== 38'd0) begin n_fail++;
      $display("FAIL reset_mid: got %0b/%0d/%h want 0/0/0", wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    n_chk++; if (hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid_hazard: got %0b want 0", hazard_o); end
    exu_valid_i = 0;
    step();
    rst_n = 1'b1;
    step(); step();
    n_chk++; if (wb_flag_o !== 1'b0 || hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_post: flag=%0b hazard=%0b want 0/0", wb_flag_o, hazard_o); end
    rs1_i = 0;
  endtask

  task automatic collide(input bit lsu_first, input string tag);
    issue(5'd3); issue(5'd4);
    exu_valid_i = 1; exu_rd_i = 5'd3; exu_data_i = 32'h3333_0003;
    lsu_valid_i = 1; lsu_rd_i = 5'd4; lsu_data_i = 32'h4444_0004;
    #1;
    n_chk++; if (lsu_ready_o !== lsu_first || exu_ready_o !== !lsu_first) begin n_fail++;
      $display("FAIL %s_grant1: lsu=%0b exu=%0b want lsu=%0b", tag, lsu_ready_o, exu_ready_o, lsu_first); end
    step();
    if (lsu_first) lsu_valid_i = 0; else exu_valid_i = 0;
    n_chk++; if (wb_flag_o !== 1'b1 || wb_reg_addr_o !== (lsu_first ? 5'd4 : 5'd3) ||
                 wb_wdata_o !== (lsu_first ? 32'h4444_0004 : 32'h3333_0003)) begin n_fail++;
      $display("FAIL %s_wb1: %0b/%0d/%h", tag, wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    #1;
    n_chk++; if (lsu_ready_o !== !lsu_first || exu_ready_o !== lsu_first) begin n_fail++;
      $display("FAIL %s_grant2: lsu=%0b exu=%0b want lsu=%0b", tag, lsu_ready_o, exu_ready_o, !lsu_first); end
    step();
    exu_valid_i = 0; lsu_valid_i = 0;
    n_chk++; if (wb_flag_o !== 1'b1 || wb_reg_addr_o !== (lsu_first ? 5'd3 : 5'd4) ||
                 wb_wdata_o !== (lsu_first ? 32'h3333_0003 : 32'h4444_0004)) begin n_fail++;
      $display("FAIL %s_wb2: %0b/%0d/%h", tag, wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    step();
  endtask

  task automatic test_collision();
    collide(FIRST_LSU, "collide_a");
    collide(FIRST_LSU, "collide_b");
  endtask

  task automatic test_single_exu();
    issue(5'd5);
    rs1_i = 5'd5;
    #1;
    n_chk++; if (hazard_o !== 1'b1) begin n_fail++;
      $display("FAIL exu_hazard_cnt1: got %0b want 1", hazard_o); end
    exu_valid_i = 1; exu_rd_i = 5'd5; exu_data_i = 32'hDEADBEEF;
    #1;
    n_chk++; if (exu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin n_fail++;
      $display("FAIL exu_ready: exu=%0b lsu=%0b want 1/0", exu_ready_o, lsu_ready_o); end
    step();
    exu_valid_i = 0;
    n_chk++; if (wb_flag_o !== 1'b1 || wb_reg_addr_o !== 5'd5 || wb_wdata_o !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL exu_wb: got %0b/%0d/%h want 1/5/deadbeef", wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    n_chk++; if (hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL exu_bypass: hazard=%0b want 0", hazard_o); end
    step();
    n_chk++; if (wb_flag_o !== 1'b0 || wb_reg_addr_o !== 5'd5 || wb_wdata_o !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL exu_hold: got %0b/%0d/%h want 0/5/deadbeef", wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    n_chk++; if (hazard_o !== 1'b0) begin n_fail++;
      $display("FAIL exu_cnt0: hazard=%0b want 0", hazard_o); end
    rs1_i = 0;
  endtask

  task automatic test_back_to_back();
    // Lone EXU win, then a collision: round-robin now favours LSU too.
    issue(5'd3);
    exu_valid_i = 1; exu_rd_i = 5'd3; exu_data_i = 32'h0000_0033;
    step();
    exu_valid_i = 0;
    step();
    collide(1'b1, "b2b");
  endtask

  task automatic commit_exu(input logic [4:0] rd);
    exu_valid_i = 1; exu_rd_i = rd; exu_data_i = {27'd0, rd};
    step();
    exu_valid_i = 0;
  endtask

  task automatic test_hazard();
    issue(5'd7);
    rs1_i = 5'd7;
    #1;
    n_chk++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL haz_issue: got %0b want 1", hazard_o); end
    step();
    n_chk++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL haz_hold: got %0b want 1", hazard_o); end
    commit_exu(5'd7);
    n_chk++; if (hazard_o !== 1'b0 || wb_flag_o !== 1'b1) begin n_fail++;
      $display("FAIL haz_bypass: hazard=%0b flag=%0b want 0/1", hazard_o, wb_flag_o); end
    step();
    // Two outstanding writes, checked through rs2.
    rs1_i = 0; rs2_i = 5'd7;
    issue(5'd7); issue(5'd7);
    commit_exu(5'd7);
    n_chk++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL haz_two_first: got %0b want 1", hazard_o); end
    step();
    n_chk++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL haz_two_left: got %0b want 1", hazard_o); end
    commit_exu(5'd7);
    n_chk++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL haz_two_last: got %0b want 0", hazard_o); end
    step();
    rs2_i = 0;
  endtask

  task automatic test_saturation();
    issue(5'd9); issue(5'd9); issue(5'd9);
    issue_rd_i = 5'd9;
    #1;
    n_chk++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL sat_full: ready=%0b want 0", issue_ready_o); end
    issue(5'd9);  // ignored while saturated
    commit_exu(5'd9);
    issue_rd_i = 5'd9;
    n_chk++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL sat_commit_cycle: ready=%0b want 0", issue_ready_o); end
    step();
    n_chk++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL sat_release: ready=%0b want 1", issue_ready_o); end
    // cnt=2: issue in the same cycle the commit is presented.
    commit_exu(5'd9);
    issue(5'd9);
    issue_rd_i = 5'd9;
    n_chk++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL sat_same_cycle: ready=%0b want 1", issue_ready_o); end
    issue(5'd9);
    issue_rd_i = 5'd9;
    n_chk++; if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL sat_refill: ready=%0b want 0", issue_ready_o); end
    issue_rd_i = 0;
  endtask

  task automatic test_x0();
    rs1_i = 0; rs2_i = 0;
    lsu_valid_i = 1; lsu_rd_i = 5'd0; lsu_data_i = 32'h1234;
    #1;
    n_chk++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", lsu_ready_o); end
    step();
    lsu_valid_i = 0;
    n_chk++; if (wb_flag_o !== 1'b0 || wb_reg_addr_o !== 5'd0 || wb_wdata_o !== 32'h1234) begin n_fail++;
      $display("FAIL x0_wb: got %0b/%0d/%h want 0/0/1234", wb_flag_o, wb_reg_addr_o, wb_wdata_o); end
    n_chk++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL x0_hazard: got %0b want 0", hazard_o); end
    issue(5'd0);
    issue_rd_i = 5'd0;
    n_chk++; if (hazard_o !== 1'b0 || issue_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL x0_issue: hazard=%0b ready=%0b want 0/1", hazard_o, issue_ready_o); end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_single_exu();
    test_back_to_back();
    test_hazard();
    test_saturation();
    test_x0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
